// File: rtl/cvp_pkg.sv
// Shared definitions for the CVP vector ALU: opcodes, FSM states and a
// constant-foldable ceil(log2) helper.
package cvp_pkg;

   typedef enum logic [1:0] {
      OP_VADD = 2'b00,
      OP_VDOT = 2'b01,
      OP_SMUL = 2'b10,
      OP_NOP  = 2'b11
   } cvp_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } cvp_state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/cvp_lane.sv
// One combinational element lane: wrapped sum, full-width signed product and
// the per-element overflow bit relevant to the current opcode.
module cvp_lane
   import cvp_pkg::*;
#(
   parameter int EW = 16
) (
   input  logic signed [EW-1:0]   i_a,
   input  logic signed [EW-1:0]   i_b,
   input  logic signed [EW-1:0]   i_scalar,
   input  cvp_op_t                i_op,
   output logic signed [EW-1:0]   o_sum,
   output logic signed [2*EW-1:0] o_prod,
   output logic                   o_ovf
);

   logic signed [EW-1:0] w_mul_b;
   logic [EW:0]          w_prod_hi;

   always_comb begin
      w_mul_b   = (i_op == OP_SMUL) ? i_scalar : i_b;
      o_sum     = i_a + i_b;
      o_prod    = (2*EW)'(i_a) * (2*EW)'(w_mul_b);
      w_prod_hi = o_prod[2*EW-1:EW-1];
      o_ovf     = 1'b0;
      case (i_op)
         OP_VADD: o_ovf = (i_a[EW-1] == i_b[EW-1]) && (o_sum[EW-1] != i_a[EW-1]);
         // Product fits in EW bits only if the top EW+1 bits are a pure sign run.
         OP_SMUL: o_ovf = !((&w_prod_hi) || !(|w_prod_hi));
         default: o_ovf = 1'b0;
      endcase
   end

endmodule

// File: rtl/cvp_vec_alu.sv
// Multi-cycle vector ALU: VADD, SMUL and VDOT over VLEN elements, LANES per beat.
// Start is sampled only in IDLE; Busy is high in RUN; Done pulses for the one DONE cycle.
module cvp_vec_alu
   import cvp_pkg::*;
#(
   parameter int EW    = 16,
   parameter int VLEN  = 16,
   parameter int LANES = 4
) (
   input  logic               Clk1,
   input  logic               Reset,
   input  logic               Start,
   input  logic [1:0]         Op,
   input  logic [EW*VLEN-1:0] VecA,
   input  logic [EW*VLEN-1:0] VecB,
   input  logic [EW-1:0]      ScalarIn,
   output logic               Busy,
   output logic               Done,
   output logic [EW*VLEN-1:0] VecOut,
   output logic [EW-1:0]      ScalarOut,
   output logic               V,
   output cvp_state_t         o_dbg_state
);

   localparam int BEATS = VLEN / LANES;
   localparam int BW    = (clog2(BEATS) < 1) ? 1 : clog2(BEATS);
   localparam int AW    = 2*EW + clog2(VLEN);
   localparam int VW    = EW * VLEN;
   localparam int SW    = EW * LANES;

   if (VLEN % LANES != 0) begin : g_bad_lanes
      $error("cvp_vec_alu: LANES must divide VLEN");
   end

   cvp_state_t            r_state;
   logic [BW-1:0]         r_beat;
   cvp_op_t               r_op;
   logic [VW-1:0]         r_vec_a;
   logic [VW-1:0]         r_vec_b;
   logic [EW-1:0]         r_scalar;
   logic [VW-1:0]         r_res;
   logic signed [AW-1:0]  r_acc;
   logic                  r_ovf;
   logic                  r_busy;
   logic                  r_done;
   logic [VW-1:0]         r_vec_out;
   logic [EW-1:0]         r_scalar_out;
   logic                  r_v;

   logic signed [EW-1:0]   w_lane_sum  [LANES];
   logic signed [2*EW-1:0] w_lane_prod [LANES];
   logic [LANES-1:0]       w_lane_ovf;
   logic [SW-1:0]          w_beat_res;
   logic signed [AW-1:0]   w_dot;
   logic                   w_beat_ovf;
   logic [VW-1:0]          w_res_next;
   logic signed [AW-1:0]   w_acc_next;
   logic [AW-EW:0]         w_acc_hi;
   logic                   w_acc_ovf;
   logic                   w_last;

   // Operand registers shift down one beat at a time, so lanes always read the low slice.
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      cvp_lane #(.EW(EW)) u_lane (
         .i_a      (r_vec_a[EW*l +: EW]),
         .i_b      (r_vec_b[EW*l +: EW]),
         .i_scalar (r_scalar),
         .i_op     (r_op),
         .o_sum    (w_lane_sum[l]),
         .o_prod   (w_lane_prod[l]),
         .o_ovf    (w_lane_ovf[l])
      );
   end

   always_comb begin
      w_beat_res = '0;
      w_dot      = '0;
      for (int l = 0; l < LANES; l++) begin
         w_beat_res[EW*l +: EW] = (r_op == OP_VADD) ? w_lane_sum[l] : w_lane_prod[l][EW-1:0];
         w_dot = w_dot + AW'(w_lane_prod[l]);
      end
      w_beat_ovf = |w_lane_ovf;
      // Results enter at the top and drift down; after BEATS beats beat 0 sits at element 0.
      w_res_next = VW'({w_beat_res, r_res} >> SW);
      w_acc_next = r_acc + w_dot;
      w_acc_hi   = w_acc_next[AW-1:EW-1];
      w_acc_ovf  = !((&w_acc_hi) || !(|w_acc_hi));
      w_last     = (r_beat == BW'(BEATS-1));
   end

   always_ff @(posedge Clk1) begin
      if (!Reset) begin
         r_state      <= ST_IDLE;
         r_beat       <= '0;
         r_op         <= OP_NOP;
         r_vec_a      <= '0;
         r_vec_b      <= '0;
         r_scalar     <= '0;
         r_res        <= '0;
         r_acc        <= '0;
         r_ovf        <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_vec_out    <= '0;
         r_scalar_out <= '0;
         r_v          <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (Start) begin
                  r_state  <= ST_RUN;
                  r_busy   <= 1'b1;
                  r_op     <= cvp_op_t'(Op);
                  r_vec_a  <= VecA;
                  r_vec_b  <= VecB;
                  r_scalar <= ScalarIn;
                  r_beat   <= '0;
                  r_acc    <= '0;
                  r_ovf    <= 1'b0;
               end
            end
            ST_RUN: begin
               r_vec_a <= r_vec_a >> SW;
               r_vec_b <= r_vec_b >> SW;
               r_res   <= w_res_next;
               r_acc   <= w_acc_next;
               r_ovf   <= r_ovf | w_beat_ovf;
               r_beat  <= r_beat + 1'b1;
               if (w_last) begin
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  case (r_op)
                     OP_VADD, OP_SMUL: begin
                        r_vec_out <= w_res_next;
                        r_v       <= r_ovf | w_beat_ovf;
                     end
                     OP_VDOT: begin
                        r_scalar_out <= w_acc_next[EW-1:0];
                        r_v          <= w_acc_ovf;
                     end
                     default: r_v <= 1'b0;
                  endcase
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign Busy        = r_busy;
   assign Done        = r_done;
   assign VecOut      = r_vec_out;
   assign ScalarOut   = r_scalar_out;
   assign V           = r_v;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cvp_vec_alu.sv
// Bench for cvp_vec_alu: array-level reference model checked every cycle,
// plus directed operations with literal expectations and a LANES==VLEN instance.
module tb_cvp_vec_alu;

   localparam int EW    = 16;
   localparam int VLEN  = 16;
   localparam int LANES = 4;
   localparam int VW    = EW * VLEN;
   localparam int BEATS = VLEN / LANES;
   localparam logic [1:0] VADD = 2'b00, VDOT = 2'b01, SMUL = 2'b10, NOP = 2'b11;
   localparam longint SMAX = 32767, SMIN = -32768;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          start16 = 1'b0;
   logic [1:0]    op = NOP;
   logic [VW-1:0] vec_a = '0, vec_b = '0;
   logic [EW-1:0] scalar_in = '0;
   logic          busy, done, v, busy16, done16, v16;
   logic [VW-1:0] vec_out, vec_out16;
   logic [EW-1:0] scalar_out, scalar_out16;
   cvp_pkg::cvp_state_t dbg_state, dbg_state16;

   int n_checks = 0;
   int n_err    = 0;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   cvp_vec_alu #(.EW(EW), .VLEN(VLEN), .LANES(LANES)) u_dut (
      .Clk1(clk), .Reset(rst_n), .Start(start), .Op(op), .VecA(vec_a), .VecB(vec_b),
      .ScalarIn(scalar_in), .Busy(busy), .Done(done), .VecOut(vec_out),
      .ScalarOut(scalar_out), .V(v), .o_dbg_state(dbg_state)
   );

   cvp_vec_alu #(.EW(EW), .VLEN(VLEN), .LANES(VLEN)) u_dut16 (
      .Clk1(clk), .Reset(rst_n), .Start(start16), .Op(op), .VecA(vec_a), .VecB(vec_b),
      .ScalarIn(scalar_in), .Busy(busy16), .Done(done16), .VecOut(vec_out16),
      .ScalarOut(scalar_out16), .V(v16), .o_dbg_state(dbg_state16)
   );

   task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic longint elem(input logic [VW-1:0] vv, input int i);
      logic signed [EW-1:0] e;
      e = vv[EW*i +: EW];
      return longint'(e);
   endfunction

   logic [VW-1:0] exp_q[$];
   logic [EW-1:0] exp_sc_q[$];
   logic          exp_v_q[$];
   logic [1:0]    exp_op_q[$];

   int            cyc = 0, fin_cyc = 0, free_at = 0;
   logic          m_valid = 1'b0;
   logic          m_busy = 1'b0, m_done = 1'b0, m_v = 1'b0;
   logic [VW-1:0] m_vec = '0;
   logic [EW-1:0] m_sc = '0;

   task automatic model_accept();
      logic [VW-1:0] pv;
      logic [EW-1:0] ps;
      logic          povf;
      longint        s, dot;
      pv = '0; ps = '0; povf = 1'b0; dot = 0;
      for (int i = 0; i < VLEN; i++) begin
         case (op)
            VADD: s = elem(vec_a, i) + elem(vec_b, i);
            SMUL: s = longint'($signed(scalar_in)) * elem(vec_a, i);
            VDOT: begin s = 0; dot += elem(vec_a, i) * elem(vec_b, i); end
            default: s = 0;
         endcase
         pv[EW*i +: EW] = s[EW-1:0];
         if ((op == VADD || op == SMUL) && (s > SMAX || s < SMIN)) povf = 1'b1;
      end
      if (op == VDOT) begin
         ps = dot[EW-1:0];
         povf = (dot > SMAX || dot < SMIN);
      end
      exp_q.push_back(pv);
      exp_sc_q.push_back(ps);
      exp_v_q.push_back(povf);
      exp_op_q.push_back(op);
   endtask

   always @(posedge clk) begin
      cyc++;
      if (!rst_n) begin
         m_valid = 1'b1;
         m_busy = 1'b0; m_done = 1'b0; m_v = 1'b0; m_vec = '0; m_sc = '0;
         exp_q.delete(); exp_sc_q.delete(); exp_v_q.delete(); exp_op_q.delete();
         free_at = cyc + 1;
      end else begin
         m_done = 1'b0;
         if (exp_q.size() > 0 && cyc == fin_cyc) begin
            logic [VW-1:0] pv;
            logic [EW-1:0] ps;
            logic [1:0]    po;
            pv = exp_q.pop_front();
            ps = exp_sc_q.pop_front();
            po = exp_op_q.pop_front();
            m_v = exp_v_q.pop_front();
            if (po == VADD || po == SMUL) m_vec = pv;
            if (po == VDOT) m_sc = ps;
            m_done = 1'b1;
            m_busy = 1'b0;
            free_at = cyc + 2;
         end else if (exp_q.size() == 0 && cyc >= free_at && start) begin
            model_accept();
            fin_cyc = cyc + BEATS;
            m_busy = 1'b1;
         end
      end
   end

   // ---------------- cycle compare ----------------
   always @(negedge clk) begin
      if (m_valid) begin
         check("cyc_busy", VW'(busy), VW'(m_busy));
         check("cyc_done", VW'(done), VW'(m_done));
         check("cyc_v", VW'(v), VW'(m_v));
         check("cyc_vec_out", vec_out, m_vec);
         check("cyc_scalar_out", VW'(scalar_out), VW'(m_sc));
      end
   end

   // ---------------- driver ----------------
   task automatic run_op(input logic [1:0] o, input logic [VW-1:0] a, input logic [VW-1:0] b,
                         input logic [EW-1:0] s, input string name);
      int lat, nbusy;
      lat = 0; nbusy = 0;
      @(negedge clk);
      op = o; vec_a = a; vec_b = b; scalar_in = s; start = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) begin
            start = 1'b0;
            vec_a = {8{$urandom()}};
            vec_b = {8{$urandom()}};
            scalar_in = EW'($urandom_range(0, 65535));
         end
         if (busy) nbusy++;
         if (done) begin lat = k; break; end
      end
      check({name, "_latency"}, VW'(lat), VW'(BEATS + 1));
      check({name, "_busy_cycles"}, VW'(nbusy), VW'(BEATS));
   endtask

   logic [VW-1:0] va_def, vb_def, exp3, exp_m3, v_ovf, v_2, v_3, v_100, v_s100;
   logic [EW-1:0] e;

   initial begin
      int pos[3];
      int npulse, ndone, lat;
      for (int i = 0; i < VLEN; i++) begin
         va_def[EW*i +: EW] = EW'(i);
         vb_def[EW*i +: EW] = EW'(2 * i);
         exp3[EW*i +: EW]   = EW'(3 * i);
         exp_m3[EW*i +: EW] = EW'(-3 * i);
         v_2[EW*i +: EW]    = 16'd2;
         v_3[EW*i +: EW]    = 16'd3;
         v_100[EW*i +: EW]  = 16'h0100;
      end
      v_ovf = '0; v_ovf[EW*7 +: EW] = 16'h7FFF;
      v_s100 = '0; v_s100[EW*0 +: EW] = 16'h0100;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_busy", VW'(busy), '0);
      check("rst_done", VW'(done), '0);
      check("rst_v", VW'(v), '0);
      check("rst_vec_out", vec_out, '0);
      check("rst_scalar_out", VW'(scalar_out), '0);
      check("rst_state", VW'(dbg_state), VW'(cvp_pkg::ST_IDLE));
      rst_n = 1'b1;

      run_op(VADD, va_def, vb_def, '0, "vadd_def");
      check("vadd_def_vec", vec_out, exp3);
      check("vadd_def_e15", VW'(vec_out[EW*15 +: EW]), VW'(16'h002D));
      check("vadd_def_v", VW'(v), '0);

      run_op(VADD, v_ovf, VW'(1) << (EW*7), '0, "vadd_ovf");
      check("vadd_ovf_e7", VW'(vec_out[EW*7 +: EW]), VW'(16'h8000));
      check("vadd_ovf_v", VW'(v), VW'(1));

      run_op(VADD, va_def, vb_def, '0, "vadd_clean");
      check("vadd_clean_v", VW'(v), '0);

      run_op(SMUL, va_def, '0, 16'hFFFD, "smul_m3");
      check("smul_m3_vec", vec_out, exp_m3);
      check("smul_m3_e5", VW'(vec_out[EW*5 +: EW]), VW'(16'hFFF1));
      check("smul_m3_v", VW'(v), '0);

      run_op(SMUL, v_s100, '0, 16'h0100, "smul_ovf");
      check("smul_ovf_e0", VW'(vec_out[EW*0 +: EW]), '0);
      check("smul_ovf_v", VW'(v), VW'(1));

      run_op(VADD, va_def, vb_def, '0, "vadd_pre_dot");
      run_op(VDOT, v_2, v_3, '0, "vdot_96");
      check("vdot_96_scalar", VW'(scalar_out), VW'(16'd96));
      check("vdot_96_v", VW'(v), '0);
      check("vdot_96_vec_kept", vec_out, exp3);

      run_op(VDOT, v_100, v_100, '0, "vdot_ovf");
      check("vdot_ovf_scalar", VW'(scalar_out), '0);
      check("vdot_ovf_v", VW'(v), VW'(1));
      check("vdot_ovf_vec_kept", vec_out, exp3);

      run_op(NOP, v_3, v_3, 16'h0005, "nop");
      check("nop_v", VW'(v), '0);
      check("nop_vec_kept", vec_out, exp3);
      check("nop_scalar_kept", VW'(scalar_out), '0);

      // reset in the middle of RUN
      @(negedge clk);
      op = VADD; vec_a = va_def; vec_b = v_3; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      check("midrst_busy", VW'(busy), '0);
      check("midrst_v", VW'(v), '0);
      check("midrst_vec_out", vec_out, '0);
      check("midrst_state", VW'(dbg_state), VW'(cvp_pkg::ST_IDLE));
      ndone = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("midrst_no_done", VW'(ndone), '0);
      run_op(VADD, va_def, vb_def, '0, "post_rst");
      check("post_rst_vec", vec_out, exp3);

      // Start held high: one accept per BEATS+2 cycles
      @(negedge clk);
      op = VADD; vec_a = va_def; vec_b = vb_def; start = 1'b1;
      npulse = 0;
      for (int k = 1; k <= 18; k++) begin
         @(negedge clk);
         if (done) begin
            if (npulse < 3) pos[npulse] = k;
            npulse++;
         end
      end
      start = 1'b0;
      check("held_pulses", VW'(npulse), VW'(3));
      if (npulse >= 3) begin
         check("held_first", VW'(pos[0]), VW'(BEATS + 1));
         check("held_gap1", VW'(pos[1] - pos[0]), VW'(BEATS + 2));
         check("held_gap2", VW'(pos[2] - pos[1]), VW'(BEATS + 2));
      end
      repeat (3) @(negedge clk);

      // LANES == VLEN: single-beat RUN
      op = VADD; vec_a = va_def; vec_b = vb_def; start16 = 1'b1;
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1) begin start16 = 1'b0; vec_a = '0; end
         if (done16) begin lat = k; break; end
      end
      check("l16_latency", VW'(lat), VW'(2));
      check("l16_vec", vec_out16, exp3);
      check("l16_v", VW'(v16), '0);
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
